// File: rtl/cdac_pkg.sv
// Shared definitions for the CDAC serial link receiver.
package cdac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } cdac_state_t;

    localparam int unsigned CDAC_NBITS    = 12;
    localparam logic        CDAC_IDLE_ENB = 1'b1;

endpackage

// File: rtl/cdac_serial_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line plus an edge register.
// level, rise and fall are all registered, so they stay mutually aligned.
module sync_edge #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              sync;

    assign sync = chain[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_LEVEL}};
            level <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            level <= sync;
            rise  <= sync & ~level;
            fall  <= ~sync & level;
        end
    end

endmodule

// File: rtl/cdac_serial_rx.sv
// CDAC serial link receiver: oversamples ENB/CK/DAT, shifts in an NBITS word MSB
// first while ENB is low, and length-checks the frame when ENB deasserts.
module cdac_serial_rx
    import cdac_pkg::*;
#(
    parameter int unsigned NBITS       = CDAC_NBITS,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic             CDAC_ENB_LV_B,
    input  logic             CDAC_CK_LV,
    input  logic             CDAC_DAT_LV,
    output logic [NBITS-1:0] DAC_VAL,
    output logic             DAC_VLD,
    output logic             FRAME_ERR,
    output logic             BUSY,
    output logic [CNT_W-1:0] FRAME_CNT
);

    localparam int unsigned     BC_W    = $clog2(NBITS + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(NBITS);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(NBITS + 1);

    logic enb_lvl, enb_rise, enb_fall;
    logic ck_rise, ck_unused_lvl, ck_unused_fall;
    logic dat_lvl, dat_unused_rise, dat_unused_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(CDAC_IDLE_ENB)) u_sync_enb (
        .clk(CLK), .rst_n(RST_B), .din(CDAC_ENB_LV_B),
        .level(enb_lvl), .rise(enb_rise), .fall(enb_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_ck (
        .clk(CLK), .rst_n(RST_B), .din(CDAC_CK_LV),
        .level(ck_unused_lvl), .rise(ck_rise), .fall(ck_unused_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_dat (
        .clk(CLK), .rst_n(RST_B), .din(CDAC_DAT_LV),
        .level(dat_lvl), .rise(dat_unused_rise), .fall(dat_unused_fall)
    );

    cdac_state_t      state, state_nxt;
    logic [NBITS-1:0] shreg, shreg_nxt;
    logic [BC_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [NBITS-1:0] val_q, val_nxt;
    logic             vld_q, vld_nxt;
    logic             err_q, err_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            val_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            val_q   <= val_nxt;
            vld_q   <= vld_nxt;
            err_q   <= err_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        val_nxt     = val_q;
        vld_nxt     = 1'b0;
        err_nxt     = 1'b0;
        cnt_nxt     = cnt_q;
        unique case (state)
            IDLE: begin
                // Level test also opens a frame whose ENB fall landed during CHECK or reset.
                if (enb_fall || !enb_lvl) begin
                    shreg_nxt   = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (enb_rise) begin
                    state_nxt = CHECK;
                end else if (ck_rise && !enb_lvl) begin
                    shreg_nxt = {shreg[NBITS-2:0], dat_lvl};
                    if (bit_cnt != BC_SAT) begin
                        bit_cnt_nxt = bit_cnt + BC_W'(1);
                    end
                end
            end
            CHECK: begin
                if (bit_cnt == BC_FULL) begin
                    val_nxt = shreg;
                    vld_nxt = 1'b1;
                    cnt_nxt = cnt_q + CNT_W'(1);
                end else begin
                    err_nxt = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign DAC_VAL   = val_q;
    assign DAC_VLD   = vld_q;
    assign FRAME_ERR = err_q;
    assign BUSY      = (state == SHIFT);
    assign FRAME_CNT = cnt_q;

endmodule

// File: tb/tb_cdac_serial_rx.sv
// Self-checking bench for cdac_serial_rx: frame-level expectation queue plus
// literal checkpoints for the directed scenarios.
module tb_cdac_serial_rx;

    localparam int unsigned NB   = 12;
    localparam int unsigned SYNC = 2;
    localparam int unsigned CW   = 8;

    logic          clk   = 1'b0;
    logic          rst_b = 1'b1;
    logic          enb   = 1'b1;
    logic          ck    = 1'b0;
    logic          dat   = 1'b0;
    logic [NB-1:0] dac_val;
    logic          dac_vld;
    logic          frame_err;
    logic          busy;
    logic [CW-1:0] frame_cnt;

    always #5 clk = ~clk;

    cdac_serial_rx #(.NBITS(NB), .SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .CLK(clk), .RST_B(rst_b),
        .CDAC_ENB_LV_B(enb), .CDAC_CK_LV(ck), .CDAC_DAT_LV(dat),
        .DAC_VAL(dac_val), .DAC_VLD(dac_vld), .FRAME_ERR(frame_err),
        .BUSY(busy), .FRAME_CNT(frame_cnt)
    );

    typedef struct {
        bit            good;
        logic [NB-1:0] val;
    } ev_t;

    ev_t           exp_q[$];
    logic [NB-1:0] m_val = '0;
    logic [CW-1:0] m_cnt = '0;
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every frame the bench closes queues one outcome; pulses consume them in order.
    initial begin : compare
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                exp_q.delete();
                m_val = '0;
                m_cnt = '0;
                check("rst_val", 32'(dac_val), 0);
                check("rst_pulses", 32'({dac_vld, frame_err}), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_cnt", 32'(frame_cnt), 0);
            end else begin
                check("pulse_excl", 32'(dac_vld & frame_err), 0);
                if (dac_vld || frame_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 32'({dac_vld, frame_err}), 0);
                    end else begin
                        ev = exp_q.pop_front();
                        check("pulse_kind", 32'({dac_vld, frame_err}), ev.good ? 32'h2 : 32'h1);
                        if (ev.good) begin
                            m_val = ev.val;
                            m_cnt = m_cnt + 1'b1;
                        end
                    end
                end
                check("dac_val", 32'(dac_val), 32'(m_val));
                check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
            end
        end
    end

    task automatic ck_bit(input logic b, input int unsigned half);
        dat = b;
        repeat (half) @(negedge clk);
        ck = 1'b1;
        repeat (half) @(negedge clk);
        ck = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] data, input int unsigned nbits,
                              input int unsigned half, input bit coinc, input bit measure);
        ev_t         ev;
        int unsigned lat;
        bit          seen;
        @(negedge clk);
        enb = 1'b0;
        if (coinc) begin
            ck = 1'b1;
            repeat (half) @(negedge clk);
            ck = 1'b0;
        end
        for (int i = int'(nbits) - 1; i >= 0; i--) ck_bit(data[i], half);
        repeat (half) @(negedge clk);
        if (measure && nbits > 0) check("busy_mid", 32'(busy), 1);
        enb     = 1'b1;
        ev.good = (nbits == NB);
        ev.val  = data[NB-1:0];
        exp_q.push_back(ev);
        if (measure) begin
            @(posedge clk);
            lat  = 0;
            seen = 0;
            while (!seen && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
                if (dac_vld || frame_err) seen = 1;
            end
            check("latency", lat, SYNC + 2);
            check("busy_after", 32'(busy), 0);
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin : stim
        logic [15:0]   data;
        logic [NB-1:0] last;
        int unsigned   n;
        int unsigned   r;

        #1 rst_b = 1'b0;
        repeat (10) @(negedge clk);
        rst_b = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_val", 32'(dac_val), 0);
        check("idle_cnt", 32'(frame_cnt), 0);
        check("idle_busy", 32'(busy), 0);

        send_frame(16'h0A5C, 12, 8, 0, 1);
        drain();
        check("good_val", 32'(dac_val), 32'h0A5C);
        check("good_cnt", 32'(frame_cnt), 1);

        send_frame(16'h07FF, 11, 8, 0, 1);
        drain();
        check("short_val", 32'(dac_val), 32'h0A5C);
        check("short_cnt", 32'(frame_cnt), 1);

        send_frame(16'h1234, 13, 8, 0, 1);
        drain();
        check("long_val", 32'(dac_val), 32'h0A5C);
        check("long_cnt", 32'(frame_cnt), 1);

        send_frame(16'h0000, 0, 8, 0, 1);
        drain();
        check("empty_cnt", 32'(frame_cnt), 1);

        send_frame(16'h0001, 12, 8, 1, 1);
        drain();
        check("coinc_val", 32'(dac_val), 32'h0001);
        check("coinc_cnt", 32'(frame_cnt), 2);

        send_frame(16'h03FF, 12, 8, 0, 0);
        send_frame(16'h0800, 12, 8, 0, 0);
        drain();
        check("b2b_val", 32'(dac_val), 32'h0800);
        check("b2b_cnt", 32'(frame_cnt), 4);

        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 7);
            case (r)
                0, 1, 2, 3: n = 12;
                4:          n = 11;
                5:          n = 13;
                6:          n = 14;
                default:    n = $urandom_range(0, 10);
            endcase
            data = 16'($urandom);
            send_frame(data, n, $urandom_range(3, 8), ($urandom_range(0, 3) == 0),
                       bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();

        // Reset mid-frame, then let the tail of the same frame finish after release.
        @(negedge clk);
        enb = 1'b0;
        for (int i = 0; i < 6; i++) ck_bit(1'b1, 6);
        #2 rst_b = 1'b0;
        #1;
        check("midrst_val", 32'(dac_val), 0);
        check("midrst_busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        #2 rst_b = 1'b1;
        for (int i = 0; i < 3; i++) ck_bit(1'b1, 6);
        repeat (6) @(negedge clk);
        enb = 1'b1;
        exp_q.push_back('{good: 1'b0, val: '0});
        drain();
        check("tail_val", 32'(dac_val), 0);
        check("tail_cnt", 32'(frame_cnt), 0);

        last = '0;
        for (int f = 0; f < 256; f++) begin
            data = 16'($urandom);
            last = data[NB-1:0];
            send_frame(data, 12, $urandom_range(3, 5), 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        check("wrap_cnt", 32'(frame_cnt), 0);
        check("wrap_val", 32'(dac_val), 32'(last));

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdac_serial_rx.md
Name: cdac_serial_rx

Overview:
- Receiver end of the comparator-threshold DAC serial link driven by the FPGA on CDAC_ENB_LV_B / CDAC_CK_LV / CDAC_DAT_LV.
- Synthesizable; used in the board emulator and in simulation tops to capture and check every DAC load the firmware issues.
- Oversamples the three asynchronous link lines in its own clock domain and shifts in an NBITS word, MSB first, while enable is low.
- Length-checks the frame on enable deassertion, then publishes the word or flags an error.

Parameters:
- NBITS, 12: DAC word length in bits, MSB first.
- SYNC_STAGES, 2: synchronizer flops per input line; minimum 2.
- CNT_W, 8: width of the good-frame counter.

Ports:
- CLK  in  1  oversampling clock, at least 2*(SYNC_STAGES+1) times the CDAC_CK_LV rate.
- RST_B  in  1  asynchronous active-low reset.
- CDAC_ENB_LV_B  in  1  frame enable, active low, asynchronous to CLK.
- CDAC_CK_LV  in  1  serial clock; data sampled on its rising edge.
- CDAC_DAT_LV  in  1  serial data.
- DAC_VAL  out  NBITS  last correctly framed DAC word.
- DAC_VLD  out  1  one-CLK pulse when DAC_VAL is updated.
- FRAME_ERR  out  1  one-CLK pulse when a frame had the wrong bit count.
- BUSY  out  1  high while a frame is open.
- FRAME_CNT  out  CNT_W  count of good frames; wraps from all-ones to 0.

Behaviour:
- Reset: every flop clears asynchronously while RST_B is low.
  - DAC_VAL=0, DAC_VLD=0, FRAME_ERR=0, BUSY=0, FRAME_CNT=0.
  - Synchronizers load the idle levels: ENB=1, CK=0, DAT=0.
  - FSM goes to IDLE.
- Input conditioning:
  - Each input passes through a SYNC_STAGES flop chain.
  - One further register on the synchronized ENB and CK gives edge detection.
  - ck_rise = CK now 1, previous 0. enb_fall / enb_rise are defined the same way on ENB.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: on enb_fall, clear the shift register and the bit counter, set BUSY=1, go to SHIFT.
  - SHIFT, ck_rise with ENB low: shift the synchronized DAT into the LSB (shreg <= {shreg[NBITS-2:0],dat}) and increment the bit counter.
  - Bit counter saturates at NBITS+1, so over-length frames are still detected.
  - SHIFT, enb_rise: go to CHECK. BUSY drops in the same cycle the CHECK state is entered.
  - CHECK, one cycle:
    - If bit count == NBITS: DAC_VAL <= shreg, DAC_VLD pulses, FRAME_CNT increments.
    - Otherwise FRAME_ERR pulses and DAC_VAL holds.
    - Return to IDLE.
- Latency: DAC_VLD / FRAME_ERR assert exactly SYNC_STAGES+2 CLK cycles after the first CLK edge that samples CDAC_ENB_LV_B high.
- Simultaneous events:
  - ck_rise in the same cycle as enb_rise: the clock edge is ignored, because deassertion wins.
  - ck_rise in the same cycle as enb_fall: the clock edge is ignored; the first bit needs a later rise.
  - ck_rise while in IDLE or CHECK: ignored.
- Frame with zero clocks: FRAME_ERR.
- Back-to-back frames: an enb_fall arriving while in CHECK is seen as soon as IDLE is re-entered, because ENB is still low.
  - Implementation: IDLE enters SHIFT when ENB is low, not only on enb_fall.
- Reset mid-frame: the partial frame is discarded with no pulse. The receiver restarts in IDLE.
  - If ENB is still low at reset release, the remainder of that frame is captured and ends with FRAME_ERR.
- DAC_VLD and FRAME_ERR are never high in the same cycle.

Decomposition:
- Shared package cdac_pkg holds:
  - the state enum (IDLE, SHIFT, CHECK);
  - CDAC_NBITS = 12;
  - CDAC_IDLE_ENB = 1'b1.
- One sub-module, sync_edge: a SYNC_STAGES synchronizer plus edge register.
  - Outputs: sync level, rise, fall.
  - Instantiated three times. The DAT instance leaves its edge outputs unused.

Test Plan:
- Reset/idle: hold RST_B=0 for 10 CLK, release with ENB=1 -> all outputs 0 and no pulses for 100 CLK.
- Good frame: shift 12'hA5C MSB first, with CK high/low each 8 CLK -> DAC_VAL=12'hA5C, single DAC_VLD pulse, FRAME_CNT=1, pulse at SYNC_STAGES+2 cycles after ENB rise.
- Short and long frames:
  - 11 clocks -> FRAME_ERR pulse, DAC_VAL stays 12'hA5C, FRAME_CNT stays 1.
  - 13 clocks -> FRAME_ERR pulse, DAC_VAL stays 12'hA5C.
- Coincident edges: CK rise in the same CLK as ENB fall, then 12 more clocks of 12'h001 -> DAC_VAL=12'h001, the first edge not counted.
- Back-to-back: frames 12'h3FF then 12'h800 with ENB high for only 1 CLK between them -> two DAC_VLD pulses in order, FRAME_CNT +2.
- Reset mid-frame and wrap:
  - RST_B low after 6 bits -> no pulse, DAC_VAL=0.
  - 256 good frames -> FRAME_CNT wraps to 0.
